parall_bus_slave: RTL and testbench
===================================

Name: parall_bus_slave

Overview:
- Parametrised successor to the team's asynchronous parallel-bus register slave.
- Host (MCU/DSP) drives cs_n/rd_n/wr_n/addr and a bidirectional data bus, all asynchronous to sclk.
- Block provides NREG read/write control registers and NREG read-only status registers, with per-register write/read strobes to the fabric.
- Accesses to unmapped addresses and illegal accesses are counted in a saturating error counter.

Parameters:
- DW, 16, data bus and register width.
- AW, 8, address width; must satisfy 2^AW >= 2*NREG.
- NREG, 8, number of RW registers (addr 0..NREG-1) and RO registers (addr NREG..2*NREG-1).
- SYNC_STAGES, 3, synchroniser depth for all host inputs; minimum 2.

Ports:
- sclk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- cs_n  in  1  host chip select, async, active-low.
- rd_n  in  1  host read strobe, async, active-low.
- wr_n  in  1  host write strobe, async, active-low.
- addr  in  AW  host address, async.
- data  inout  DW  host data bus, tri-stated when not reading.
- stat_in  in  NREG*DW  RO register sources; slice i is read at address NREG+i.
- reg_q  out  NREG*DW  RW register contents; slice i belongs to address i.
- wr_pulse  out  NREG  one-cycle strobe on commit to RW register i.
- rd_pulse  out  NREG  one-cycle strobe when RO register i is snapshotted.
- err_cnt  out  8  saturating count of illegal or unmapped accesses.

Behaviour:
- Clock and reset: clock sclk; reset rst_n, asynchronous, active-low.
- Reset values: all reg_q 0, wr_pulse 0, rd_pulse 0, err_cnt 0, data high-Z, FSM IDLE.
- Synchronisation: cs_n, rd_n, wr_n pass through SYNC_STAGES flops (reset to 1). addr and data pass through equal-depth pipelines (reset to 0), so samples stay aligned with the controls. All FSM decisions use the synced values: cs_s, rd_s, wr_s, addr_s, data_s.
- FSM states: IDLE, WR_ACT, RD_ACT, ERR_WAIT.
- IDLE transitions:
  - cs_s=0, wr_s=0, rd_s=1 -> WR_ACT.
  - cs_s=0, rd_s=0, wr_s=1 -> RD_ACT.
  - cs_s=0, rd_s=0, wr_s=0 -> ERR_WAIT; err_cnt increments.
- WR_ACT:
  - Each cycle, latch addr_s/data_s into hold registers.
  - Exit on the first cycle with wr_s=1 or cs_s=1 (whichever comes first) -> commit the held data to IDLE.
  - Commit when held addr < NREG: reg_q[addr] <= held data, wr_pulse[addr]=1 for exactly one cycle.
  - Commit when held addr >= NREG (RO or unmapped): no write, err_cnt increments.
  - Pin-to-commit latency: SYNC_STAGES+1 sclk after the wr_n rising edge.
- RD_ACT entry: read data is snapshotted once into r_data.
  - addr < NREG: reg_q slice.
  - NREG <= addr < 2*NREG: stat_in slice, plus rd_pulse[addr-NREG]=1 for one cycle.
  - Otherwise: 0, and err_cnt increments.
- RD_ACT drive and exit:
  - data is driven with r_data while state==RD_ACT and cs_s=0 and rd_s=0; otherwise high-Z.
  - Exit to IDLE when rd_s=1 or cs_s=1.
  - Bus release latency is SYNC_STAGES+1 cycles after rd_n rises; host bus turnaround must exceed this.
- RD_ACT, wr_s falls while reading: drive stops immediately, err_cnt increments, -> ERR_WAIT.
- ERR_WAIT: no drive, no writes; return to IDLE when cs_s=1, or when rd_s=1 and wr_s=1.
- err_cnt saturates at 255 and does not wrap.
- Reset mid-access: pending write is discarded, bus released immediately (async), FSM to IDLE.

Optional Feature:
- Macro PI_BYTE_EN. Only meaningful for DW=16.
- With PI_BYTE_EN: adds input ports be_n[1:0] (async, active-low, synchronised like addr).
  - Commit writes only the bytes whose be_n bit is 0.
  - Both bits 1 at commit: no write, no wr_pulse, err_cnt increments.
  - Reads ignore be_n.
- Without PI_BYTE_EN: no be_n port; full-word writes.

Decomposition:
- Package pbs_pkg holds the FSM state enum, err_cnt width constant (8), and the ERR_SAT constant (255).
- One natural sub-module, pbs_sync: a parametrised width/depth flop chain with a reset value. It is instanced for the controls (reset 1) and for addr/data (reset 0).

Test Plan:
- Write 0x1234 to addr 3; wr_n low for 10 sclk -> reg_q[3]=0x1234 and a single wr_pulse[3] 4 cycles after the wr_n rise; other registers unchanged.
- After the above, read addr 3 -> data=0x1234 while rd_n low (after sync delay), high-Z within 4 cycles of the rd_n rise.
- Read addr NREG+2 with stat_in slice 2=0xBEEF -> data=0xBEEF, rd_pulse[2] for one cycle, err_cnt unchanged.
- Write addr 0x20 and read addr 0x30 (unmapped) -> no reg_q change, read returns 0x0000, err_cnt=2.
- rd_n and wr_n low together -> data stays high-Z, no writes, err_cnt+1; 300 such accesses -> err_cnt=255.
- Assert rst_n low mid-write (wr_n still low) -> reg_q unchanged, wr_pulse 0, data high-Z. With PI_BYTE_EN, write 0xAABB with be_n=2'b10 to reg 1 holding 0x1111 -> 0x11BB.

Source files
------------

// File: rtl/pbs_pkg.sv
// Shared types and constants for the parallel-bus register slave.
package pbs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ACT   = 2'd1,
        RD_ACT   = 2'd2,
        ERR_WAIT = 2'd3
    } pbs_state_t;

    localparam int             ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
        return (cnt == ERR_SAT) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/parall_bus_slave_if.sv
// Host-side strobes and address of the parallel bus; optional be_n under PI_BYTE_EN.
interface parall_bus_slave_if #(
    parameter int AW = 8
);
    logic          cs_n;
    logic          rd_n;
    logic          wr_n;
    logic [AW-1:0] addr;
`ifdef PI_BYTE_EN
    logic [1:0]    be_n;
`endif

    modport master (
        output cs_n, rd_n, wr_n, addr
`ifdef PI_BYTE_EN
        , output be_n
`endif
    );

    modport slave (
        input cs_n, rd_n, wr_n, addr
`ifdef PI_BYTE_EN
        , input be_n
`endif
    );
endinterface

// File: rtl/pbs_sync.sv
// Parametrised flop chain with a selectable reset level, used to bring host pins into sclk.
module pbs_sync #(
    parameter int   W       = 1,
    parameter int   DEPTH   = 3,
    parameter logic RST_BIT = 1'b0
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= {W{RST_BIT}};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/parall_bus_slave.sv
// Asynchronous parallel-bus slave with NREG RW and NREG RO registers and a saturating error count.
// Optional byte-lane writes are enabled by defining PI_BYTE_EN.
//
// state    | meaning
// IDLE     | no access in progress, bus released
// WR_ACT   | host write strobe low, capturing addr/data every cycle
// RD_ACT   | read snapshot taken, driving data while strobes stay low
// ERR_WAIT | illegal access seen, wait for host to release strobes
module parall_bus_slave
    import pbs_pkg::*;
#(
    parameter int DW          = 16,
    parameter int AW          = 8,
    parameter int NREG        = 8,
    parameter int SYNC_STAGES = 3
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    parall_bus_slave_if.slave    bus,
    inout  wire  [DW-1:0]        data,
    input  logic [NREG*DW-1:0]   stat_in,
    output logic [NREG*DW-1:0]   reg_q,
    output logic [NREG-1:0]      wr_pulse,
    output logic [NREG-1:0]      rd_pulse,
    output logic [ERR_W-1:0]     err_cnt
);
    localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef PI_BYTE_EN
    localparam int PW = AW + DW + 2;
`else
    localparam int PW = AW + DW;
`endif

    logic [2:0]    ctl_s;
    logic          cs_s, rd_s, wr_s;
    logic [PW-1:0] pipe_d, pipe_q;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] data_s;

    pbs_sync #(.W(3), .DEPTH(DEPTH), .RST_BIT(1'b1)) u_sync_ctl (
        .sclk  (sclk),
        .rst_n (rst_n),
        .d     ({bus.cs_n, bus.rd_n, bus.wr_n}),
        .q     (ctl_s)
    );

`ifdef PI_BYTE_EN
    logic [1:0] be_s;
    assign pipe_d = {bus.be_n, bus.addr, data};
    assign be_s   = pipe_q[PW-1 -: 2];
`else
    assign pipe_d = {bus.addr, data};
`endif

    pbs_sync #(.W(PW), .DEPTH(DEPTH), .RST_BIT(1'b0)) u_sync_dat (
        .sclk  (sclk),
        .rst_n (rst_n),
        .d     (pipe_d),
        .q     (pipe_q)
    );

    assign cs_s   = ctl_s[2];
    assign rd_s   = ctl_s[1];
    assign wr_s   = ctl_s[0];
    assign addr_s = pipe_q[AW+DW-1 -: AW];
    assign data_s = pipe_q[DW-1:0];

    pbs_state_t    state;
    logic [DW-1:0] regs [NREG];
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic [DW-1:0] r_data;
    logic [DW-1:0] rd_val;
    logic [NREG-1:0] rd_ro;
    logic [NREG-1:0] wr_sel;
    logic          rd_ok;
    logic          wr_ok;
    logic          drive;

    always_comb begin
        rd_val = '0;
        rd_ro  = '0;
        rd_ok  = 1'b0;
        wr_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr_s == AW'(i)) begin
                rd_val = regs[i];
                rd_ok  = 1'b1;
            end
            if (addr_s == AW'(NREG + i)) begin
                rd_val   = stat_in[i*DW +: DW];
                rd_ro[i] = 1'b1;
                rd_ok    = 1'b1;
            end
            if (hold_addr == AW'(i)) wr_sel[i] = 1'b1;
        end
    end

`ifdef PI_BYTE_EN
    logic [1:0] hold_be;
    assign wr_ok = (|wr_sel) && (hold_be != 2'b11);

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [1:0]    be_n);
        logic [DW-1:0] m;
        m = old_w;
        if (!be_n[0]) m[7:0]  = new_w[7:0];
        if (!be_n[1]) m[15:8] = new_w[15:8];
        return m;
    endfunction
`else
    assign wr_ok = |wr_sel;
`endif

    // A rising wr_s commits what was captured before it, never the sample taken on the exit cycle.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            r_data    <= '0;
            wr_pulse  <= '0;
            rd_pulse  <= '0;
            err_cnt   <= '0;
`ifdef PI_BYTE_EN
            hold_be   <= 2'b11;
`endif
        end else begin
            wr_pulse <= '0;
            rd_pulse <= '0;
            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        if (!wr_s && rd_s) begin
                            state     <= WR_ACT;
                            hold_addr <= addr_s;
                            hold_data <= data_s;
`ifdef PI_BYTE_EN
                            hold_be   <= be_s;
`endif
                        end else if (!rd_s && wr_s) begin
                            state    <= RD_ACT;
                            r_data   <= rd_val;
                            rd_pulse <= rd_ro;
                            if (!rd_ok) err_cnt <= sat_inc(err_cnt);
                        end else if (!rd_s && !wr_s) begin
                            state   <= ERR_WAIT;
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end
                end
                WR_ACT: begin
                    if (wr_s || cs_s) begin
                        state <= IDLE;
                        if (wr_ok) begin
                            for (int i = 0; i < NREG; i++) begin
                                if (wr_sel[i]) begin
`ifdef PI_BYTE_EN
                                    regs[i] <= byte_merge(regs[i], hold_data, hold_be);
`else
                                    regs[i] <= hold_data;
`endif
                                end
                            end
                            wr_pulse <= wr_sel;
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end else begin
                        hold_addr <= addr_s;
                        hold_data <= data_s;
`ifdef PI_BYTE_EN
                        hold_be   <= be_s;
`endif
                    end
                end
                RD_ACT: begin
                    if (rd_s || cs_s) begin
                        state <= IDLE;
                    end else if (!wr_s) begin
                        state   <= ERR_WAIT;
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                ERR_WAIT: begin
                    if (cs_s || (rd_s && wr_s)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_regq
        assign reg_q[g*DW +: DW] = regs[g];
    end

    // Drive decision is combinational on synced strobes so a write strobe during a read cuts the bus at once.
    assign drive = (state == RD_ACT) && !cs_s && !rd_s && wr_s;
    assign data  = drive ? r_data : {DW{1'bz}};

endmodule

// File: tb/tb_parall_bus_slave.sv
// Directed, table-driven bench for parall_bus_slave; the data bus idles at all-ones through a pull.
module tb_parall_bus_slave;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NREG = 8;
    localparam int SYNC = 3;
    localparam logic [DW-1:0] RELEASED = 16'hFFFF;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    tri1 [DW-1:0] data;
    logic [DW-1:0] tb_dat = '0;
    logic tb_oe = 1'b0;
    logic [NREG*DW-1:0] stat_in;
    logic [NREG*DW-1:0] reg_q;
    logic [NREG-1:0] wr_pulse, rd_pulse;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    parall_bus_slave_if #(.AW(AW)) bus ();

    parall_bus_slave #(.DW(DW), .AW(AW), .NREG(NREG), .SYNC_STAGES(SYNC)) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .bus      (bus),
        .data     (data),
        .stat_in  (stat_in),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse),
        .rd_pulse (rd_pulse),
        .err_cnt  (err_cnt)
    );

    assign data = tb_oe ? tb_dat : {DW{1'bz}};

    always #10 sclk = ~sclk;

    logic [NREG-1:0] wr_acc = '0, rd_acc = '0;
    int rd_cnt = 0;
    always @(negedge sclk) begin
        wr_acc = wr_acc | wr_pulse;
        rd_acc = rd_acc | rd_pulse;
        if (rd_pulse != 0) rd_cnt = rd_cnt + 1;
    end

    logic [DW-1:0] model [NREG];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NREG*DW-1:0] model_flat();
        logic [NREG*DW-1:0] f;
        for (int i = 0; i < NREG; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    task automatic clear_mon();
        wr_acc = '0;
        rd_acc = '0;
        rd_cnt = 0;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be,
                              output int pos, output int cnt);
        @(negedge sclk);
        bus.addr = a;
        tb_dat = d;
        tb_oe = 1'b1;
        bus.cs_n = 1'b0;
`ifdef PI_BYTE_EN
        bus.be_n = be;
`endif
        if (be === 2'bxx) pos = -1;
        @(negedge sclk);
        bus.wr_n = 1'b0;
        repeat (10) @(negedge sclk);
        bus.wr_n = 1'b1;
        pos = 0;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sclk);
            if (wr_pulse != 0) begin
                cnt++;
                if (pos == 0) pos = k;
            end
            if (k == 2) begin
                bus.cs_n = 1'b1;
                tb_oe = 1'b0;
            end
        end
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] val, output int rel);
        @(negedge sclk);
        bus.addr = a;
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        repeat (SYNC + 3) @(negedge sclk);
        val = data;
        bus.rd_n = 1'b1;
        rel = 99;
        for (int k = 1; k <= 10; k++) begin
            @(negedge sclk);
            if (rel == 99 && data === RELEASED) rel = k;
        end
        bus.cs_n = 1'b1;
        repeat (3) @(negedge sclk);
    endtask

    typedef struct {
        bit              is_rd;
        logic [AW-1:0]   a;
        logic [DW-1:0]   wdata;
        logic [DW-1:0]   exp_rd;
        logic [NREG-1:0] exp_wr_mask;
        logic [NREG-1:0] exp_rd_mask;
        logic [7:0]      exp_err;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int pos, cnt, rel;
        logic [DW-1:0] val;

        vecs[0]  = '{0, 8'd3,    16'h1234, 16'h0000, 8'h08, 8'h00, 8'd0};
        vecs[1]  = '{1, 8'd3,    16'h0000, 16'h1234, 8'h00, 8'h00, 8'd0};
        vecs[2]  = '{1, 8'd10,   16'h0000, 16'hBEEF, 8'h00, 8'h04, 8'd0};
        vecs[3]  = '{0, 8'h20,   16'h5555, 16'h0000, 8'h00, 8'h00, 8'd1};
        vecs[4]  = '{1, 8'h30,   16'h0000, 16'h0000, 8'h00, 8'h00, 8'd2};
        vecs[5]  = '{0, 8'd7,    16'hA5A5, 16'h0000, 8'h80, 8'h00, 8'd2};
        vecs[6]  = '{1, 8'd7,    16'h0000, 16'hA5A5, 8'h00, 8'h00, 8'd2};
        vecs[7]  = '{0, 8'd8,    16'h7777, 16'h0000, 8'h00, 8'h00, 8'd3};
        vecs[8]  = '{1, 8'd15,   16'h0000, 16'hB007, 8'h00, 8'h80, 8'd3};
        vecs[9]  = '{1, 8'd0,    16'h0000, 16'h0000, 8'h00, 8'h00, 8'd3};
        vecs[10] = '{0, 8'd0,    16'hFFFE, 16'h0000, 8'h01, 8'h00, 8'd3};
        vecs[11] = '{1, 8'd0,    16'h0000, 16'hFFFE, 8'h00, 8'h00, 8'd3};
        vecs[12] = '{1, 8'd16,   16'h0000, 16'h0000, 8'h00, 8'h00, 8'd4};

        for (int i = 0; i < NREG; i++) begin
            stat_in[i*DW +: DW] = (i == 2) ? 16'hBEEF : 16'hB000 + 16'(i);
            model[i] = '0;
        end
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.addr = '0;
`ifdef PI_BYTE_EN
        bus.be_n = 2'b00;
`endif
        repeat (3) @(negedge sclk);
        check("reset_data_hiz", data, RELEASED);
        check("reset_reg_q", reg_q, '0);
        check("reset_err_cnt", err_cnt, 8'd0);
        check("reset_pulses", {wr_pulse, rd_pulse}, '0);
        rst_n = 1'b1;
        repeat (3) @(negedge sclk);

        for (int v = 0; v < 13; v++) begin
            clear_mon();
            if (vecs[v].is_rd) begin
                host_read(vecs[v].a, val, rel);
                check($sformatf("v%0d_rdata", v), val, vecs[v].exp_rd);
                check($sformatf("v%0d_release_le4", v), rel <= SYNC + 1, 1'b1);
                check($sformatf("v%0d_rd_pulse", v), rd_acc, vecs[v].exp_rd_mask);
                if (vecs[v].exp_rd_mask != 0) check($sformatf("v%0d_rd_pulse_len", v), rd_cnt, 1);
            end else begin
                host_write(vecs[v].a, vecs[v].wdata, 2'b00, pos, cnt);
                if (vecs[v].a < NREG) model[vecs[v].a] = vecs[v].wdata;
                check($sformatf("v%0d_wr_pulse", v), wr_acc, vecs[v].exp_wr_mask);
                if (vecs[v].exp_wr_mask != 0) begin
                    check($sformatf("v%0d_wr_pulse_pos", v), pos, SYNC + 1);
                    check($sformatf("v%0d_wr_pulse_cnt", v), cnt, 1);
                end
            end
            check($sformatf("v%0d_err_cnt", v), err_cnt, vecs[v].exp_err);
            check($sformatf("v%0d_reg_q", v), reg_q, model_flat());
        end

        // write strobe falling during a read aborts the drive
        @(negedge sclk);
        bus.addr = 8'd3;
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        repeat (SYNC + 3) @(negedge sclk);
        check("abort_driven", data, 16'h1234);
        bus.wr_n = 1'b0;
        repeat (SYNC + 2) @(negedge sclk);
        check("abort_released", data, RELEASED);
        check("abort_err_cnt", err_cnt, 8'd5);
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        repeat (6) @(negedge sclk);

        // rd_n and wr_n together
        clear_mon();
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        bus.wr_n = 1'b0;
        repeat (SYNC + 3) @(negedge sclk);
        check("both_hiz", data, RELEASED);
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        repeat (6) @(negedge sclk);
        check("both_err_cnt", err_cnt, 8'd6);
        check("both_no_write", wr_acc, '0);
        check("both_reg_q", reg_q, model_flat());

        for (int n = 0; n < 300; n++) begin
            bus.cs_n = 1'b0;
            bus.rd_n = 1'b0;
            bus.wr_n = 1'b0;
            repeat (SYNC + 2) @(negedge sclk);
            bus.cs_n = 1'b1;
            bus.rd_n = 1'b1;
            bus.wr_n = 1'b1;
            repeat (SYNC + 2) @(negedge sclk);
        end
        check("err_saturated", err_cnt, 8'd255);
        check("sat_reg_q", reg_q, model_flat());

        // reset during an active read releases the bus immediately
        @(negedge sclk);
        bus.addr = 8'd3;
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        repeat (SYNC + 3) @(negedge sclk);
        check("rstrd_driven", data, 16'h1234);
        #3 rst_n = 1'b0;
        #1 check("rstrd_released", data, RELEASED);
        check("rstrd_err_cnt", err_cnt, 8'd0);
        @(negedge sclk);
        bus.rd_n = 1'b1;
        bus.cs_n = 1'b1;
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        repeat (6) @(negedge sclk);

        // reset during a write discards it
        clear_mon();
        bus.addr = 8'd3;
        tb_dat = 16'h9999;
        tb_oe = 1'b1;
        bus.cs_n = 1'b0;
        @(negedge sclk);
        bus.wr_n = 1'b0;
        repeat (8) @(negedge sclk);
        rst_n = 1'b0;
        #1 check("rstwr_pulse", wr_pulse, '0);
        check("rstwr_reg_q", reg_q, model_flat());
        @(negedge sclk);
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        tb_oe = 1'b0;
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        repeat (8) @(negedge sclk);
        check("rstwr_no_pulse", wr_acc, '0);
        check("rstwr_reg_q_after", reg_q, model_flat());
        check("rstwr_err_cnt", err_cnt, 8'd0);
        check("rstwr_hiz", data, RELEASED);

`ifdef PI_BYTE_EN
        host_write(8'd1, 16'h1111, 2'b00, pos, cnt);
        check("be_full", reg_q[1*DW +: DW], 16'h1111);
        host_write(8'd1, 16'hAABB, 2'b10, pos, cnt);
        check("be_low_byte", reg_q[1*DW +: DW], 16'h11BB);
        check("be_low_pulse", cnt, 1);
        host_write(8'd1, 16'h5566, 2'b01, pos, cnt);
        check("be_high_byte", reg_q[1*DW +: DW], 16'h55BB);
        host_write(8'd1, 16'h7788, 2'b11, pos, cnt);
        check("be_none_reg", reg_q[1*DW +: DW], 16'h55BB);
        check("be_none_pulse", cnt, 0);
        check("be_none_err", err_cnt, 8'd1);
        host_read(8'd1, val, rel);
        check("be_read", val, 16'h55BB);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
